// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and the rotating-priority search for rr_arbiter8
package arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

  typedef struct packed {
    logic             found;
    logic [SEL_W-1:0] idx;
  } pick_t;

  // Scans downward so the candidate closest to ptr is the last one written and wins.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] mask,
                                    input logic [SEL_W-1:0]   ptr);
    pick_t            res;
    logic [SEL_W-1:0] cand;
    res = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = ptr + SEL_W'(i);
      if (mask[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/decoder8.sv
// rtl/decoder8.sv - 3-to-8 one-hot decoder with enable
module decoder8 (
  input  logic [2:0] sel,
  input  logic       enable,
  output logic [7:0] y
);

  always_comb begin
    y = '0;
    if (enable) y[sel] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - eight-client round-robin arbiter with hold-time preemption
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   req,
  output logic         grant_valid,
  output logic [2:0]   grant_sel,
  output logic [7:0]   grant,
  output logic         preempted
);

  localparam int CNT_W     = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
  localparam logic [CNT_W-1:0] HOLD_LAST_C = CNT_W'(HOLD_LAST);

  arb_state_t         state, state_n;
  logic [SEL_W-1:0]   ptr, ptr_n;
  logic [CNT_W-1:0]   hold_cnt, hold_n;
  logic [SEL_W-1:0]   sel_n;
  logic               valid_n;
  logic               pre_n;

  logic [NUM_REQ-1:0] owner_mask;
  logic [NUM_REQ-1:0] others;
  pick_t              pick_req;
  pick_t              pick_oth;
  logic               take;
  logic [SEL_W-1:0]   take_idx;

  assign owner_mask = NUM_REQ'(1) << grant_sel;
  assign others     = req & ~owner_mask;
  assign pick_req   = rr_pick(req, ptr);
  assign pick_oth   = rr_pick(others, ptr);

  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    hold_n   = hold_cnt;
    sel_n    = grant_sel;
    valid_n  = grant_valid;
    pre_n    = 1'b0;
    take     = 1'b0;
    take_idx = pick_oth.idx;

    case (state)
      ARB_IDLE: begin
        valid_n = 1'b0;
        if (pick_req.found) begin
          take     = 1'b1;
          take_idx = pick_req.idx;
        end
      end
      ARB_BUSY: begin
        if (!req[grant_sel]) begin
          if (pick_oth.found) begin
            take = 1'b1;
          end else begin
            state_n = ARB_IDLE;
            valid_n = 1'b0;
          end
        end else if ((MAX_HOLD != 0) && (hold_cnt == HOLD_LAST_C) && (others != '0)) begin
          take  = 1'b1;
          pre_n = 1'b1;
        end else if (hold_cnt != HOLD_LAST_C) begin
          hold_n = hold_cnt + 1'b1;
        end
      end
      default: begin
        state_n = ARB_IDLE;
        valid_n = 1'b0;
      end
    endcase

    if (take) begin
      state_n = ARB_BUSY;
      sel_n   = take_idx;
      valid_n = 1'b1;
      ptr_n   = take_idx + 1'b1;
      hold_n  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ARB_IDLE;
      ptr         <= '0;
      hold_cnt    <= '0;
      grant_sel   <= '0;
      grant_valid <= 1'b0;
      preempted   <= 1'b0;
    end else begin
      state       <= state_n;
      ptr         <= ptr_n;
      hold_cnt    <= hold_n;
      grant_sel   <= sel_n;
      grant_valid <= valid_n;
      preempted   <= pre_n;
    end
  end

  // Grant decodes registered state only, keeping req off the grant path.
  decoder8 u_grant_dec (
    .sel    (grant_sel),
    .enable (grant_valid),
    .y      (grant)
  );

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb/tb_rr_arbiter8.sv - vector table and scoreboard bench for rr_arbiter8
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'hFF;
  logic       grant_valid;
  logic [2:0] grant_sel;
  logic [7:0] grant;
  logic       preempted;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] req;
    logic       v;
    logic [2:0] sel;
    logic       pre;
  } vec_t;

  typedef struct {
    logic       v;
    logic [2:0] sel;
    logic       pre;
    string      name;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  rr_arbiter8 #(.MAX_HOLD(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .grant_valid (grant_valid),
    .grant_sel   (grant_sel),
    .grant       (grant),
    .preempted   (preempted)
  );

  always #5 clk = ~clk;

  task automatic add(input logic [7:0] r, input logic v, input logic [2:0] s,
                     input logic p, input int n);
    vec_t t;
    t.req = r;
    t.v   = v;
    t.sel = s;
    t.pre = p;
    for (int i = 0; i < n; i++) vecs.push_back(t);
  endtask

  task automatic check_out(input string name, input logic v, input logic [2:0] s,
                           input logic p);
    logic [7:0] eg;
    logic [7:0] one;
    one = 8'h01;
    eg  = v ? (one << s) : 8'h00;
    checks++;
    if (grant_valid !== v || grant_sel !== s || grant !== eg || preempted !== p) begin
      errors++;
      $display("FAIL %s: got valid=%b sel=%0d grant=%h pre=%b, want valid=%b sel=%0d grant=%h pre=%b",
               name, grant_valid, grant_sel, grant, preempted, v, s, eg, p);
    end
  endtask

  task automatic step(input vec_t t, input string name);
    exp_t e;
    exp_t got;
    @(negedge clk);
    req    = t.req;
    e.v    = t.v;
    e.sel  = t.sel;
    e.pre  = t.pre;
    e.name = name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      got = sb.pop_front();
      check_out(got.name, got.v, got.sel, got.pre);
    end
  endtask

  initial begin
    logic [7:0] one;
    vec_t       t;
    one = 8'h01;

    // reset held with every client requesting
    repeat (2) @(posedge clk);
    #1;
    check_out("reset_hold", 1'b0, 3'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    req = 8'h00;

    add(8'hFF, 1, 3'd0, 0, 1);                 // first grant after reset
    add(8'h00, 0, 3'd0, 0, 1);
    add(8'h24, 1, 3'd2, 0, 3);                 // 2 then 5 back-to-back
    add(8'h20, 1, 3'd5, 0, 3);
    add(8'h00, 0, 3'd5, 0, 1);
    add(8'h80, 1, 3'd7, 0, 1);                 // ptr wraps to 0
    add(8'h00, 0, 3'd7, 0, 1);
    add(8'hFF, 1, 3'd0, 0, 1);                 // strict rotation, all requesting
    for (int k = 1; k <= 9; k++)
      add(~(one << ((k - 1) % 8)), 1, 3'(k % 8), 0, 1);
    add(8'h00, 0, 3'd1, 0, 1);
    add(8'h08, 1, 3'd3, 0, 1);                 // preemption after 4 contended cycles
    add(8'h48, 1, 3'd3, 0, 3);
    add(8'h48, 1, 3'd6, 1, 1);
    add(8'h48, 1, 3'd6, 0, 3);
    add(8'h48, 1, 3'd3, 1, 1);
    add(8'h00, 0, 3'd3, 0, 1);
    add(8'h02, 1, 3'd1, 0, 20);                // sole requester never preempted
    add(8'h00, 0, 3'd1, 0, 1);
    add(8'h01, 1, 3'd0, 0, 1);                 // newcomer on release edge
    add(8'h10, 1, 3'd4, 0, 1);
    add(8'h00, 0, 3'd4, 0, 1);
    add(8'h20, 1, 3'd5, 0, 2);                 // owner 5 busy before reset

    for (int i = 0; i < vecs.size(); i++)
      step(vecs[i], $sformatf("vec%0d", i));

    // asynchronous reset in the middle of a cycle
    #2;
    rst = 1'b1;
    #1;
    check_out("async_reset", 1'b0, 3'd0, 1'b0);
    @(posedge clk);
    #1;
    check_out("reset_held", 1'b0, 3'd0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    req = 8'h00;

    // ptr restarted at 0 makes 5 beat 7
    t.req = 8'hA0; t.v = 1'b1; t.sel = 3'd5; t.pre = 1'b0;
    step(t, "post_reset_5");
    t.req = 8'h80; t.v = 1'b1; t.sel = 3'd7; t.pre = 1'b0;
    step(t, "post_reset_7");
    t.req = 8'h00; t.v = 1'b0; t.sel = 3'd7; t.pre = 1'b0;
    step(t, "post_reset_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Eight-requester round-robin arbiter that shares one resource (memory port, register-file write port, bus) between up to eight clients. It registers a winner index plus a valid flag and expands them through the existing `decoder8` into a one-hot grant vector. A hold-time limit stops a single client from starving the others. The block sits between the requesting units and the shared resource's select/enable inputs.

## Interface
- `MAX_HOLD`, default 16: maximum consecutive grant cycles while others are waiting; 0 disables preemption.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  8  per-client request; the client holds it high until done with the resource.
- `grant_valid`  out  1  registered; the resource is granted to `grant_sel`.
- `grant_sel`  out  3  registered; index of the current owner.
- `grant`  out  8  one-hot; `decoder8(sel=grant_sel, enable=grant_valid)`; all zero when not valid.
- `preempted`  out  1  registered; one-cycle pulse on the cycle after an ownership change forced by `MAX_HOLD`.

## Operation
- State (registered): `state` ∈ {IDLE, BUSY}, `ptr[2:0]` (highest-priority index), `hold_cnt`, `grant_sel`, `grant_valid`, `preempted`.
- Winner search: the first set bit of the candidate mask scanning `ptr, ptr+1, … ptr+7`, all mod 8. There is no winner if the mask is zero.
- On the edge that installs winner W: `grant_sel←W`, `grant_valid←1`, `ptr←(W+1) mod 8`, `hold_cnt←0`, `state←BUSY`.
- IDLE:
  - Candidate mask = `req`.
  - With a winner: install it.
  - Otherwise: stay in IDLE with `grant_valid=0`.
- BUSY with owner O:
  - If `req[O]=0` (release): candidate mask = `req` with bit O cleared. With a winner, install it back-to-back with no dead cycle. Otherwise go to IDLE with `grant_valid←0`; `grant_sel` keeps its old value.
  - Else, if `MAX_HOLD≠0`, `hold_cnt=MAX_HOLD-1`, and `req & ~(1<<O) ≠ 0`: preempt. Install the winner from the mask excluding O and set `preempted←1`. O keeps its request and competes again once it returns to priority.
  - Else: keep O and do `hold_cnt←hold_cnt+1`, saturating at `MAX_HOLD-1`.
- `preempted` is 0 on every cycle except the one following a preemption.
- Boundaries:
  - The owner is alone: it holds indefinitely, and the counter saturates at `MAX_HOLD-1`.
  - All eight requesting: ownership rotates strictly 0→1→…→7→0 as each releases.
  - Owner releases and another request rises on the same cycle: the newcomer is eligible immediately.
  - `ptr` wraps from 7 to 0.
- Reset: `rst` high at any time forces `state=IDLE`, `ptr=0`, `hold_cnt=0`, `grant_sel=0`, `grant_valid=0`, `preempted=0`, so `grant=8'h00`. A grant in flight is dropped without handshake.

## Timing
- Request-to-grant latency is 1 cycle: `req` sampled high at edge k gives `grant_valid` high after edge k.
- Release-to-next-grant latency is 1 edge. The grant index changes on the same edge that sees the release.
- `grant_valid`, `grant_sel` and `preempted` are flop outputs. `grant` is combinational from flops only, with no path from `req` to `grant`.
- A client samples its grant as the cycle after the edge. Deasserting `req` in cycle n means the grant is gone from cycle n+1.
- Preemption timing: the owner keeps the grant for exactly `MAX_HOLD` cycles when contended.

## Structure
- Package `arb_pkg`:
  - `NUM_REQ=8`, `SEL_W=3`.
  - `typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t`.
  - Function `rr_pick(mask, ptr)` returning index plus found flag.
- Sub-module: the existing `decoder8` produces `grant`. The rest is one `always_ff` for state and one `always_comb` for the next state.
- `hold_cnt` width is `$clog2(MAX_HOLD)`, minimum 1.

## Test plan
- Reset with `req=8'hFF` asserted: `grant=8'h00` during reset. First edge after release → `grant_sel=0`, `grant=8'h01`.
- `req=8'b0010_0100` starting at `ptr=0`, each owner holding 3 cycles then releasing → grants 2 then 5, back-to-back, then IDLE with `grant=0`.
- All eight requesting, each owner releasing after 1 cycle → `grant_sel` sequence 0,1,…,7,0 with wrap and no gaps.
- `MAX_HOLD=4`, client 3 holding `req` forever, client 6 raises `req` at cycle 1 → client 3 keeps the grant for 4 cycles, then `grant_sel=6` and `preempted` pulses once.
- Sole requester with `MAX_HOLD=4` holding 20 cycles → no preemption, `grant=8'h??` constant, `preempted` stays 0.
- Assert `rst` mid-BUSY (owner 5) → `grant_valid=0` immediately (asynchronously). After release, a fresh request from 5 is granted with `ptr` restarted at 0.
